// File: rtl/cache_port.sv
// Per-core load/store front-end: tag lookup through the cache put/get handshake,
// hit/miss classification and store-hit write-back. Optional macro: CACHE_PORT_STATS_EN.
module cache_port (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_byte_en,
  input  logic [31:0] req_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_hit,
  output logic [31:0] resp_data,
  output logic        cache_put_valid,
  input  logic        cache_put_ready,
  output logic [69:0] cache_put_request,
  output logic        cache_get_valid,
  input  logic        cache_get_ready,
  input  logic [51:0] cache_get_response,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam logic [31:0] EXIT_ADDRESS0 = 32'h4000_1000;
  localparam logic [31:0] EXIT_ADDRESS1 = 32'h8000_1000;
  localparam logic [1:0]  MSI_S = 2'b01;
  localparam logic [1:0]  MSI_M = 2'b10;

  typedef enum logic [2:0] {IDLE, LOOKUP, WAIT, WRITE, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] data_q, data_d;
  logic        hit_q, hit_d;
  logic [31:0] rdata_q, rdata_d;

  logic [17:0] row_tag;
  logic [31:0] row_data;
  logic [1:0]  row_msi;
  logic        is_store, is_exit, tag_match, load_hit, store_hit;
  logic        unused_addr_lsb;

  assign {row_tag, row_data, row_msi} = cache_get_response;
  assign unused_addr_lsb = &{1'b0, addr_q[1:0]};

  assign is_store  = |be_q;
  assign is_exit   = ({addr_q[31:2], 2'b00} == EXIT_ADDRESS0) ||
                     ({addr_q[31:2], 2'b00} == EXIT_ADDRESS1);
  assign tag_match = (row_tag == addr_q[31:14]);
  // 2'b11 falls out of both terms, so it behaves as Invalid
  assign load_hit  = tag_match && ((row_msi == MSI_S) || (row_msi == MSI_M));
  assign store_hit = tag_match && (row_msi == MSI_M);

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    be_d              = be_q;
    data_d            = data_q;
    hit_d             = hit_q;
    rdata_d           = rdata_q;
    req_ready         = 1'b0;
    resp_valid        = 1'b0;
    cache_put_valid   = 1'b0;
    cache_put_request = '0;
    cache_get_valid   = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          be_d    = req_byte_en;
          data_d  = req_data;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        cache_put_valid   = 1'b1;
        cache_put_request = {4'b0000, addr_q[31:14], addr_q[13:2], 32'h0, 1'b0, 2'b00, 1'b0};
        if (cache_put_ready) state_d = WAIT;
      end
      WAIT: begin
        cache_get_valid = 1'b1;
        if (cache_get_ready) begin
          hit_d   = is_store ? store_hit : load_hit;
          rdata_d = row_data;
          // exit stores are forwarded even on a miss so the simulator sees them
          state_d = (is_store && (store_hit || is_exit)) ? WRITE : RESP;
        end
      end
      WRITE: begin
        cache_put_valid   = 1'b1;
        cache_put_request = {be_q, addr_q[31:14], addr_q[13:2], data_q, 1'b0, 2'b00, 1'b1};
        if (cache_put_ready) state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!RST_N) begin
      req_ready         = 1'b0;
      resp_valid        = 1'b0;
      cache_put_valid   = 1'b0;
      cache_put_request = '0;
      cache_get_valid   = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      hit_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge CLK) begin
    addr_q <= addr_d;
    be_q   <= be_d;
    data_q <= data_d;
  end

  assign resp_hit  = hit_q;
  assign resp_data = rdata_q;

`ifdef CACHE_PORT_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (resp_valid && resp_ready) begin
      if (hit_q) hit_cnt_d  = hit_cnt_q + 32'd1;
      else       miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_port.sv
// Self-checking bench for cache_port: behavioural row-store environment plus a
// rule-level reference model of hit/miss, returned data and forwarded writes.
`timescale 1ns/1ps
module tb_cache_port;

  localparam logic [31:0] EXIT0 = 32'h4000_1000;
  localparam logic [31:0] EXIT1 = 32'h8000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_byte_en = '0;
  logic [31:0] req_data = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic        resp_hit;
  logic [31:0] resp_data;
  logic        cache_put_valid;
  logic        cache_put_ready;
  logic [69:0] cache_put_request;
  logic        cache_get_valid;
  logic        cache_get_ready;
  logic [51:0] cache_get_response;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  always #5 clk = ~clk;

  cache_port dut (
    .CLK(clk), .RST_N(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_byte_en(req_byte_en), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit), .resp_data(resp_data),
    .cache_put_valid(cache_put_valid), .cache_put_ready(cache_put_ready),
    .cache_put_request(cache_put_request),
    .cache_get_valid(cache_get_valid), .cache_get_ready(cache_get_ready),
    .cache_get_response(cache_get_response),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // ---------------- cache row store environment ----------------
  logic        put_rdy = 1'b1;
  logic        hold_get = 1'b0;
  logic        rsp_pend = 1'b0;
  logic        wr_pend = 1'b0;
  logic [51:0] rsp_row = '0;
  logic [69:0] wr_req = '0;
  logic [69:0] last_wr = '0;
  logic [17:0] mem_tag  [0:4095];
  logic [31:0] mem_data [0:4095];
  logic [1:0]  mem_msi  [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_idx = '0;
  logic [17:0] pl_tag = '0;
  logic [31:0] pl_data = '0;
  logic [1:0]  pl_msi = '0;
  int          lk_cnt = 0, wr_cnt = 0, rsp_cnt = 0, exit_cnt = 0, cyc = 0;

  assign cache_put_ready    = put_rdy;
  assign cache_get_ready    = rsp_pend && !hold_get;
  assign cache_get_response = rsp_row;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en) begin
      mem_tag[pl_idx]  <= pl_tag;
      mem_data[pl_idx] <= pl_data;
      mem_msi[pl_idx]  <= pl_msi;
    end
    if (resp_valid && resp_ready) rsp_cnt <= rsp_cnt + 1;
    if (!rst_n) begin
      rsp_pend <= 1'b0;
      wr_pend  <= 1'b0;
    end else begin
      wr_pend <= 1'b0;
      if (wr_pend) begin
        mem_data[wr_req[47:36]] <= merge(mem_data[wr_req[47:36]], wr_req[35:4], wr_req[69:66]);
        if ({wr_req[65:48], wr_req[47:36], 2'b00} == EXIT0 ||
            {wr_req[65:48], wr_req[47:36], 2'b00} == EXIT1) exit_cnt <= exit_cnt + 1;
      end
      if (cache_get_valid && cache_get_ready) rsp_pend <= 1'b0;
      if (cache_put_valid && put_rdy) begin
        if (cache_put_request[0]) begin
          wr_pend <= 1'b1;
          wr_req  <= cache_put_request;
          last_wr <= cache_put_request;
          wr_cnt  <= wr_cnt + 1;
        end else begin
          rsp_pend <= 1'b1;
          rsp_row  <= {mem_tag[cache_put_request[47:36]], mem_data[cache_put_request[47:36]],
                       mem_msi[cache_put_request[47:36]]};
          lk_cnt   <= lk_cnt + 1;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [17:0] ref_tag  [0:4095];
  logic [31:0] ref_data [0:4095];
  logic [1:0]  ref_msi  [0:4095];
  int          m_hit = 0, m_miss = 0;
  int          n_checks = 0, n_fail = 0;
  bit          rnd_stall = 1'b0;

  task automatic preload(input logic [11:0] i, input logic [17:0] t, input logic [31:0] d, input logic [1:0] m);
    pl_en = 1'b1; pl_idx = i; pl_tag = t; pl_data = d; pl_msi = m;
    ref_tag[i] = t; ref_data[i] = d; ref_msi[i] = m;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                        output logic h, output logic [31:0] rd, output int lat, output bit ok);
    int n;
    bit done;
    n = 0; ok = 1'b0; done = 1'b0; lat = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_addr = a; req_byte_en = be; req_data = d;
    while (!done && lat < 200) begin
      @(negedge clk);
      lat++;
      req_valid = 1'b0;
      if (resp_valid) begin
        done = 1'b1;
      end else if (rnd_stall) begin
        put_rdy    = 1'($urandom_range(0, 1));
        resp_ready = 1'($urandom_range(0, 1));
      end
    end
    ok = done; h = resp_hit; rd = resp_data;
    put_rdy = 1'b1; resp_ready = 1'b1;
  endtask

  task automatic xact(input string nm, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] d, input int exp_lat);
    logic [11:0] i;
    logic        st, ex, ehit, ewr, ghit;
    logic [31:0] edata, gdata;
    int          lat, w0;
    bit          ok;
    i  = a[13:2];
    st = (be != 4'b0000);
    ex = ({a[31:2], 2'b00} == EXIT0) || ({a[31:2], 2'b00} == EXIT1);
    edata = ref_data[i];
    if (st) ehit = (ref_tag[i] == a[31:14]) && (ref_msi[i] == 2'b10);
    else    ehit = (ref_tag[i] == a[31:14]) && (ref_msi[i] == 2'b01 || ref_msi[i] == 2'b10);
    ewr = st && (ehit || ex);
    if (ewr) ref_data[i] = merge(ref_data[i], d, be);
    if (ehit) m_hit++; else m_miss++;
    w0 = wr_cnt;
    do_req(a, be, d, ghit, gdata, lat, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL %s resp_timeout: got no response, required one", nm); end
    n_checks++; if (ghit !== ehit) begin n_fail++; $display("FAIL %s hit: got %b required %b", nm, ghit, ehit); end
    n_checks++; if (gdata !== edata) begin n_fail++; $display("FAIL %s data: got %h required %h", nm, gdata, edata); end
    n_checks++; if ((wr_cnt - w0) != (ewr ? 1 : 0)) begin n_fail++; $display("FAIL %s writes: got %0d required %0d", nm, wr_cnt - w0, ewr ? 1 : 0); end
    if (exp_lat >= 0) begin
      n_checks++; if (lat != exp_lat) begin n_fail++; $display("FAIL %s latency: got %0d required %0d", nm, lat, exp_lat); end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if ({req_ready, resp_valid, cache_put_valid, cache_get_valid} !== 4'b0000) begin n_fail++; $display("FAIL reset_valids: got %b required 0000", {req_ready, resp_valid, cache_put_valid, cache_get_valid}); end
    n_checks++; if ({resp_hit, resp_data} !== 33'h0) begin n_fail++; $display("FAIL reset_resp: got %b/%h required 0/0", resp_hit, resp_data); end
    n_checks++; if (cache_put_request !== 70'h0) begin n_fail++; $display("FAIL reset_put_request: got %h required 0", cache_put_request); end
    n_checks++; if ({hit_count, miss_count} !== 64'h0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d required 0/0", hit_count, miss_count); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
    m_hit = 0; m_miss = 0;
  endtask

  task automatic test_load_hit();
    preload(12'h004, 18'h00010, 32'hDEADBEEF, 2'b01);
    xact("load_hit", 32'h0004_0010, 4'b0000, 32'h0, 3);
  endtask

  task automatic test_store_hit();
    preload(12'h004, 18'h00010, 32'hDEADBEEF, 2'b10);
    xact("store_hit", 32'h0004_0010, 4'b0011, 32'h0000_CAFE, 4);
    n_checks++; if (last_wr[0] !== 1'b1 || last_wr[69:66] !== 4'b0011 || last_wr[35:4] !== 32'h0000_CAFE) begin n_fail++; $display("FAIL store_hit_put: got %h required ign=1 be=0011 data=0000cafe", last_wr); end
    xact("store_hit_readback", 32'h0004_0010, 4'b0000, 32'h0, 3);
    n_checks++; if (ref_data[12'h004] !== 32'hDEADCAFE) begin n_fail++; $display("FAIL store_hit_model: got %h required deadcafe", ref_data[12'h004]); end
  endtask

  task automatic test_store_s_mismatch();
    preload(12'h004, 18'h00010, 32'hDEADBEEF, 2'b01);
    xact("store_to_s", 32'h0004_0010, 4'b1111, 32'h1234_5678, 3);
    xact("tag_mismatch", 32'h0004_4010, 4'b0000, 32'h0, 3);
    xact("row_unchanged", 32'h0004_0010, 4'b0000, 32'h0, 3);
  endtask

  task automatic test_exit_store();
    int e0;
    preload(12'h400, 18'h00000, 32'h0, 2'b00);
    e0 = exit_cnt;
    xact("exit0_store", EXIT0, 4'b1111, 32'h0, 4);
    xact("exit1_store", EXIT1, 4'b0001, 32'h0000_00A5, 4);
    @(negedge clk);
    n_checks++; if (exit_cnt - e0 != 2) begin n_fail++; $display("FAIL exit_finish: got %0d required 2", exit_cnt - e0); end
  endtask

  task automatic test_back_to_back();
    int c0;
    preload(12'h030, 18'h00123, 32'hA5A5_0001, 2'b10);
    xact("b2b_first", 32'h048C_00C0, 4'b0000, 32'h0, 3);
    c0 = cyc;
    xact("b2b_second", 32'h048C_00C0, 4'b0000, 32'h0, 3);
    n_checks++; if (cyc - c0 != 4) begin n_fail++; $display("FAIL b2b_period: got %0d required 4", cyc - c0); end
  endtask

  task automatic test_backpressure();
    int          lk0, r0, n;
    logic [69:0] snap;
    logic        h;
    logic [31:0] d;
    preload(12'h008, 18'h00022, 32'h1122_3344, 2'b01);
    ref_data[12'h008] = 32'h1122_3344;
    lk0 = lk_cnt; r0 = rsp_cnt;
    put_rdy = 1'b0; resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0008_8020; req_byte_en = 4'b0000;
    @(negedge clk);
    req_valid = 1'b0;
    snap = cache_put_request;
    n_checks++; if (snap !== {4'b0, 18'h00022, 12'h008, 32'h0, 4'b0000}) begin n_fail++; $display("FAIL bp_lookup_req: got %h required lookup of 08820", snap); end
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (!cache_put_valid || cache_put_request !== snap) begin n_fail++; $display("FAIL bp_put_stable: got %b/%h required 1/%h", cache_put_valid, cache_put_request, snap); end
      @(negedge clk);
    end
    put_rdy = 1'b1;
    n = 0;
    while (!resp_valid && n < 20) begin @(negedge clk); n++; end
    h = resp_hit; d = resp_data;
    n_checks++; if (!resp_valid || h !== 1'b1 || d !== 32'h1122_3344) begin n_fail++; $display("FAIL bp_resp: got v=%b h=%b d=%h required 1/1/11223344", resp_valid, h, d); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (!resp_valid || resp_hit !== h || resp_data !== d || cache_put_request !== 70'h0) begin n_fail++; $display("FAIL bp_resp_stable: got v=%b h=%b d=%h req=%h", resp_valid, resp_hit, resp_data, cache_put_request); end
    end
    resp_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_resp_drop: got %b required 0", resp_valid); end
    n_checks++; if (lk_cnt - lk0 != 1 || rsp_cnt - r0 != 1) begin n_fail++; $display("FAIL bp_counts: got lookups %0d resps %0d required 1/1", lk_cnt - lk0, rsp_cnt - r0); end
    m_hit++;
  endtask

  task automatic test_random();
    logic [11:0] idxs [4];
    logic [11:0] i;
    logic [17:0] t;
    logic [31:0] a;
    logic [3:0]  be;
    idxs[0] = 12'h010; idxs[1] = 12'h011; idxs[2] = 12'h012; idxs[3] = 12'h400;
    for (int k = 0; k < 4; k++)
      preload(idxs[k], (k == 3 && $urandom_range(0, 1) == 1) ? 18'h10000 : 18'h5 + 18'($urandom_range(0, 1)),
              $urandom, 2'($urandom_range(0, 3)));
    rnd_stall = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        i = idxs[$urandom_range(0, 3)];
        preload(i, (i == 12'h400) ? 18'h10000 : 18'h5 + 18'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)));
      end
      if ($urandom_range(0, 7) == 0) begin
        a = ($urandom_range(0, 1) == 1) ? EXIT1 : EXIT0;
        a[1:0] = 2'($urandom_range(0, 3));
      end else begin
        i = idxs[$urandom_range(0, 2)];
        t = 18'h5 + 18'($urandom_range(0, 1));
        a = {t, i, 2'($urandom_range(0, 3))};
      end
      be = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
      xact("random", a, be, $urandom, -1);
    end
    rnd_stall = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stats(input string nm);
    int eh, em;
`ifdef CACHE_PORT_STATS_EN
    eh = m_hit; em = m_miss;
`else
    eh = 0; em = 0;
`endif
    n_checks++; if (hit_count !== 32'(eh)) begin n_fail++; $display("FAIL %s hit_count: got %0d required %0d", nm, hit_count, eh); end
    n_checks++; if (miss_count !== 32'(em)) begin n_fail++; $display("FAIL %s miss_count: got %0d required %0d", nm, miss_count, em); end
  endtask

  task automatic test_reset_mid();
    int n, r0;
    preload(12'h020, 18'h00007, 32'h0BAD_F00D, 2'b01);
    hold_get = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0001_C080; req_byte_en = 4'b0000;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!cache_get_valid && n < 20) begin @(negedge clk); n++; end
    n_checks++; if (cache_get_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_wait: got get_valid %b required 1", cache_get_valid); end
    rst_n = 1'b0;
    r0 = rsp_cnt;
    @(negedge clk);
    n_checks++; if ({req_ready, resp_valid, cache_put_valid, cache_get_valid} !== 4'b0000) begin n_fail++; $display("FAIL rstmid_valids: got %b required 0000", {req_ready, resp_valid, cache_put_valid, cache_get_valid}); end
    @(negedge clk);
    hold_get = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_ready: got %b required 1", req_ready); end
    repeat (6) @(negedge clk);
    n_checks++; if (resp_valid !== 1'b0 || rsp_cnt != r0) begin n_fail++; $display("FAIL rstmid_no_resp: got valid %b resps %0d required 0/0", resp_valid, rsp_cnt - r0); end
    m_hit = 0; m_miss = 0;
    test_stats("rstmid_cleared");
  endtask

  task automatic test_stat_run();
    for (int k = 0; k < 3; k++) xact("stats_hit", 32'h0001_C080, 4'b0000, 32'h0, 3);
    xact("stats_miss_tag", 32'h0002_0080, 4'b0000, 32'h0, 3);
    xact("stats_miss_store", 32'h0001_C080, 4'b1111, 32'h5, 3);
    @(negedge clk);
    n_checks++; if (m_hit != 3 || m_miss != 2) begin n_fail++; $display("FAIL stats_model: got %0d/%0d required 3/2", m_hit, m_miss); end
    test_stats("stats_3_2");
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_load_hit();
    test_store_hit();
    test_store_s_mismatch();
    test_exit_store();
    test_back_to_back();
    test_backpressure();
    @(negedge clk);
    test_stats("directed");
    test_random();
    test_stats("random");
    test_reset_mid();
    test_stat_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
